pipe_stage_scheduler: RTL and testbench

PIPE_STAGE_SCHEDULER -- requirements
Module: pipe_stage_scheduler

---
 rtl/pipe_stage_scheduler.sv | 82 ++++++++
 tb/tb_pipe_stage_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_scheduler.sv
// Round-robin issue scheduler for a fixed-latency pipeline stage shared by NUM_REQ requesters.
// Optional output backpressure (out_ready, pipe_en stall) is enabled by PIPE_SCHED_BACKPRESSURE_EN.
module pipe_stage_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 7,
  parameter int TAG_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef PIPE_SCHED_BACKPRESSURE_EN
  input  logic               out_ready,
`endif
  output logic [NUM_REQ-1:0] req_ready,
  output logic               issue_valid,
  output logic [TAG_W-1:0]   issue_sel,
  output logic               pipe_en,
  output logic               out_valid,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam logic [TAG_W:0] NUM_REQ_X = (TAG_W+1)'(NUM_REQ);

  logic [TAG_W-1:0]         r_rr_ptr;
  logic [LATENCY-1:0]       r_vld;
  logic [LATENCY*TAG_W-1:0] r_tag;

  logic [TAG_W-1:0] w_cand [NUM_REQ];
  logic [TAG_W-1:0] w_pick;
  logic             w_found;

  // Candidate index for each search offset, wrapped modulo NUM_REQ (need not be a power of two).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [TAG_W:0] w_sum;
      assign w_sum       = {1'b0, r_rr_ptr} + (TAG_W+1)'(gi);
      assign w_cand[gi]  = (w_sum >= NUM_REQ_X) ? TAG_W'(w_sum - NUM_REQ_X) : w_sum[TAG_W-1:0];
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[w_cand[k]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[k];
      end
    end
  end

`ifdef PIPE_SCHED_BACKPRESSURE_EN
  assign pipe_en = ~out_valid | out_ready;
`else
  assign pipe_en = 1'b1;
`endif

  // Grant is suppressed while in reset or stalled so nothing transfers unrecorded.
  assign issue_valid = w_found & pipe_en & ~rst;
  assign issue_sel   = issue_valid ? w_pick : '0;
  assign req_ready   = issue_valid ? (NUM_REQ'(1) << w_pick) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_vld    <= '0;
      r_tag    <= '0;
    end else if (pipe_en) begin
      r_vld <= (r_vld << 1) | LATENCY'(issue_valid);
      r_tag <= (r_tag << TAG_W) | (LATENCY*TAG_W)'(issue_sel);
      if (issue_valid)
        r_rr_ptr <= (issue_sel == TAG_W'(NUM_REQ-1)) ? '0 : issue_sel + TAG_W'(1);
    end
  end

  assign out_valid = r_vld[LATENCY-1];
  assign out_tag   = r_tag[LATENCY*TAG_W-1 -: TAG_W];
  assign busy      = |r_vld;

endmodule

// File: tb/tb_pipe_stage_scheduler.sv
// Self-checking bench for pipe_stage_scheduler: table vectors, scoreboard model and corner sequences.
module tb_pipe_stage_scheduler;
  localparam int N  = 4;
  localparam int L  = 7;
  localparam int TW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req_valid;
  logic          out_ready;
  logic [N-1:0]  req_ready;
  logic          issue_valid, pipe_en, out_valid, busy;
  logic [TW-1:0] issue_sel, out_tag;

  logic [N-1:0]  req_valid1;
  logic [N-1:0]  req_ready1;
  logic          issue_valid1, pipe_en1, out_valid1, busy1;
  logic [TW-1:0] issue_sel1, out_tag1;

  pipe_stage_scheduler #(.NUM_REQ(N), .LATENCY(L), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
`ifdef PIPE_SCHED_BACKPRESSURE_EN
    .out_ready(out_ready),
`endif
    .req_ready(req_ready), .issue_valid(issue_valid), .issue_sel(issue_sel),
    .pipe_en(pipe_en), .out_valid(out_valid), .out_tag(out_tag), .busy(busy)
  );

  pipe_stage_scheduler #(.NUM_REQ(N), .LATENCY(1), .TAG_W(TW)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1),
`ifdef PIPE_SCHED_BACKPRESSURE_EN
    .out_ready(1'b1),
`endif
    .req_ready(req_ready1), .issue_valid(issue_valid1), .issue_sel(issue_sel1),
    .pipe_en(pipe_en1), .out_valid(out_valid1), .out_tag(out_tag1), .busy(busy1)
  );

  typedef struct { int tag; int due; } sb_t;
  typedef struct { logic [N-1:0] rv; logic [N-1:0] rdy; int sel; bit ov; int otag; } vec_t;

  sb_t  sb_q[$];
  vec_t tbl [23];
  int   m_ptr, cyc, s_cyc, n_vec, n_err;

  logic [N-1:0]  s_ready, s_ready1;
  logic          s_iv, s_pe, s_ov, s_busy, s_iv1, s_pe1, s_ov1, s_busy1;
  logic [TW-1:0] s_sel, s_tag, s_sel1, s_tag1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, s_cyc, act, exp);
    end
  endtask

  // One clock: sample at negedge, check against the scoreboard model, advance the model.
  task automatic cycle();
    int g, idx;
    bit ov_e, pe_e, busy_e;
    logic [N-1:0] rdy_e;
    sb_t e;
    @(negedge clk);
    s_cyc = cyc;
    s_ready = req_ready; s_iv = issue_valid; s_sel = issue_sel; s_pe = pipe_en;
    s_ov = out_valid; s_tag = out_tag; s_busy = busy;
    s_ready1 = req_ready1; s_iv1 = issue_valid1; s_sel1 = issue_sel1; s_pe1 = pipe_en1;
    s_ov1 = out_valid1; s_tag1 = out_tag1; s_busy1 = busy1;
    if (rst) begin
      chk("rst_req_ready", int'(s_ready), 0);
      chk("rst_issue_valid", int'(s_iv), 0);
      chk("rst_issue_sel", int'(s_sel), 0);
      chk("rst_pipe_en", int'(s_pe), 1);
      chk("rst_out_valid", int'(s_ov), 0);
      chk("rst_out_tag", int'(s_tag), 0);
      chk("rst_busy", int'(s_busy), 0);
      chk("rst_out_valid1", int'(s_ov1), 0);
      chk("rst_busy1", int'(s_busy1), 0);
      sb_q.delete();
      m_ptr = 0;
    end else begin
      ov_e   = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      busy_e = (sb_q.size() != 0);
      pe_e   = !(ov_e && !out_ready);
      g = -1;
      if (pe_e) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx[TW-1:0]]) g = idx;
        end
      end
      rdy_e = '0;
      if (g >= 0) rdy_e[g[TW-1:0]] = 1'b1;
      chk("sb_req_ready", int'(s_ready), int'(rdy_e));
      chk("sb_issue_valid", int'(s_iv), int'(g >= 0));
      chk("sb_issue_sel", int'(s_sel), (g >= 0) ? g : 0);
      chk("sb_pipe_en", int'(s_pe), int'(pe_e));
      chk("sb_out_valid", int'(s_ov), int'(ov_e));
      if (ov_e) chk("sb_out_tag", int'(s_tag), sb_q[0].tag);
      chk("sb_busy", int'(s_busy), int'(busy_e));
      if (pe_e) begin
        if (ov_e) void'(sb_q.pop_front());
        if (g >= 0) begin
          e.tag = g; e.due = cyc + L;
          sb_q.push_back(e);
          m_ptr = (g + 1) % N;
        end
      end else begin
        foreach (sb_q[i]) sb_q[i].due = sb_q[i].due + 1;
      end
    end
    @(posedge clk);
    #1;
    cyc = rst ? 0 : cyc + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_valid1 = '0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001, 0, 1'b0, 0};
    tbl[1]  = '{4'b1111, 4'b0010, 1, 1'b0, 0};
    tbl[2]  = '{4'b1111, 4'b0100, 2, 1'b0, 0};
    tbl[3]  = '{4'b1111, 4'b1000, 3, 1'b0, 0};
    tbl[4]  = '{4'b1111, 4'b0001, 0, 1'b0, 0};
    tbl[5]  = '{4'b1111, 4'b0010, 1, 1'b0, 0};
    tbl[6]  = '{4'b1111, 4'b0100, 2, 1'b0, 0};
    tbl[7]  = '{4'b1111, 4'b1000, 3, 1'b1, 0};
    tbl[8]  = '{4'b0010, 4'b0010, 1, 1'b1, 1};
    tbl[9]  = '{4'b1010, 4'b1000, 3, 1'b1, 2};
    tbl[10] = '{4'b1010, 4'b0010, 1, 1'b1, 3};
    tbl[11] = '{4'b0001, 4'b0001, 0, 1'b1, 0};
    tbl[12] = '{4'b0000, 4'b0000, 0, 1'b1, 1};
    tbl[13] = '{4'b1001, 4'b1000, 3, 1'b1, 2};
    tbl[14] = '{4'b1001, 4'b0001, 0, 1'b1, 3};
    tbl[15] = '{4'b0000, 4'b0000, 0, 1'b1, 1};
    tbl[16] = '{4'b0000, 4'b0000, 0, 1'b1, 3};
    tbl[17] = '{4'b0000, 4'b0000, 0, 1'b1, 1};
    tbl[18] = '{4'b0000, 4'b0000, 0, 1'b1, 0};
    tbl[19] = '{4'b0000, 4'b0000, 0, 1'b0, 0};
    tbl[20] = '{4'b0000, 4'b0000, 0, 1'b1, 3};
    tbl[21] = '{4'b0000, 4'b0000, 0, 1'b1, 0};
    tbl[22] = '{4'b0000, 4'b0000, 0, 1'b0, 0};

    n_vec = 0; n_err = 0; cyc = 0; s_cyc = 0; m_ptr = 0;
    rst = 1'b1; req_valid = '0; req_valid1 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Round-robin order, back-to-back results, pointer wrap past a gap.
    for (int i = 0; i < 23; i++) begin
      req_valid = tbl[i].rv;
      cycle();
      chk("tbl_req_ready", int'(s_ready), int'(tbl[i].rdy));
      chk("tbl_issue_sel", int'(s_sel), tbl[i].sel);
      chk("tbl_out_valid", int'(s_ov), int'(tbl[i].ov));
      if (tbl[i].ov) chk("tbl_out_tag", int'(s_tag), tbl[i].otag);
    end

    // Single pulse on requester 2 at cycle 10.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      req_valid = (c == 10) ? 4'b0100 : 4'b0000;
      cycle();
      chk("p_req_ready", int'(s_ready), (c == 10) ? 4 : 0);
      if (c == 10) chk("p_issue_sel", int'(s_sel), 2);
      chk("p_out_valid", int'(s_ov), int'(c == 17));
      if (c == 17) chk("p_out_tag", int'(s_tag), 2);
      chk("p_busy", int'(s_busy), int'(c >= 11 && c <= 17));
    end

    // Reset with five operations in flight drops them all.
    req_valid = 4'b1111;
    repeat (5) cycle();
    req_valid = '0;
    rst = 1'b1;
    cycle();
    chk("mr_busy", int'(s_busy), 0);
    chk("mr_out_valid", int'(s_ov), 0);
    rst = 1'b0;
    for (int c = 0; c < L + 2; c++) begin
      cycle();
      chk("mr_no_stale", int'(s_ov), 0);
      chk("mr_idle_busy", int'(s_busy), 0);
    end

    // LATENCY=1 instance with requester 1 held.
    req_valid1 = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk("l1_req_ready", int'(s_ready1), 2);
      chk("l1_issue_valid", int'(s_iv1), 1);
      chk("l1_issue_sel", int'(s_sel1), 1);
      chk("l1_pipe_en", int'(s_pe1), 1);
      chk("l1_out_valid", int'(s_ov1), int'(c >= 1));
      if (c >= 1) chk("l1_out_tag", int'(s_tag1), 1);
      chk("l1_busy", int'(s_busy1), int'(c >= 1));
    end
    req_valid1 = '0;

`ifdef PIPE_SCHED_BACKPRESSURE_EN
    // Three-cycle stall with the first result at the output.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 3 || (c >= 7 && c <= 9)) ? 4'b1111 : 4'b0000;
      out_ready = !(c >= 7 && c <= 9);
      cycle();
      if (c >= 7 && c <= 9) begin
        chk("bp_pipe_en", int'(s_pe), 0);
        chk("bp_req_ready", int'(s_ready), 0);
        chk("bp_out_valid", int'(s_ov), 1);
        chk("bp_out_tag", int'(s_tag), 0);
      end
      if (c >= 10 && c <= 12) begin
        chk("bp_rel_valid", int'(s_ov), 1);
        chk("bp_rel_tag", int'(s_tag), c - 10);
      end
      if (c == 13) chk("bp_drained", int'(s_ov), 0);
    end
    out_ready = 1'b1;
    req_valid = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
